traffic_light_controller: RTL and testbench
===========================================

Name: traffic_light_controller

Overview:
- Fixed-time Moore controller for a four-approach junction: main road direction 1 (M1), main road direction 2 (M2), main-road turn lane (MT) and side road (S).
- Steps through a six-phase cycle using per-phase cycle-count durations and drives one 3-bit one-hot lamp vector per approach.
- Standalone top-level block with no sensor inputs and a free-running sequence.

Parameters:
- T_MG, 7, cycles in phase P1 (M1+M2 green)
- T_Y, 2, cycles in every yellow phase (P2, P4, P6)
- T_TG, 5, cycles in phase P3 (M1+MT green)
- T_SG, 3, cycles in phase P5 (S green)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- light_M1  output  3  M1 lamps
- light_S  output  3  side-road lamps
- light_MT  output  3  main-turn lamps
- light_M2  output  3  M2 lamps

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Lamp encoding, one-hot, exactly one bit set at all times:
  - 3'b100 red
  - 3'b010 yellow
  - 3'b001 green
- State: phase register P1..P6 plus a duration counter (≥5 bits wide, enough for the largest parameter).
- Counting:
  - Counter increments every cycle.
  - When counter == duration-1 of the current phase: next edge advances phase and clears counter to 0.
  - Each phase therefore lasts exactly its parameter count of cycles.
- Phase table (M1, M2, MT, S):
  - P1, T_MG: green, green, red, red
  - P2, T_Y: green, yellow, red, red
  - P3, T_TG: green, red, green, red
  - P4, T_Y: yellow, red, yellow, red
  - P5, T_SG: red, red, red, green
  - P6, T_Y: red, red, red, yellow
  - P6 -> P1, wrapping forever. Full cycle = T_MG+3*T_Y+T_TG+T_SG = 21 cycles at defaults.
- Outputs: pure combinational decode of the phase register (Moore), so lamps change on the same edge as the phase.
- Reset:
  - rst high at a rising edge forces phase=P1, counter=0, regardless of current phase or count.
  - Lamps then read M1=001, M2=001, MT=100, S=100.
  - rst held high holds this state.
  - Reset mid-phase discards the remaining count.
- Safety invariants (must hold every cycle):
  - S is non-red only in P5/P6, where all main lamps are red.
  - MT and M2 are never simultaneously non-red.
- Illegal/unused phase encodings recover to P1 with counter 0 on the next edge; outputs all red while illegal.
- All parameters must be ≥1; T_Y=1 gives single-cycle yellows.

Test Plan:
- Reset: rst=1 for 1 edge, then 0 -> M1=001, M2=001, MT=100, S=100 immediately after the reset edge. Cycle index 0 = first edge with rst low.
- Default sequence: run 21 cycles after reset -> P1 cycles 0-6, P2 7-8 (M2=010), P3 9-13 (MT=001, M2=100), P4 14-15 (M1=010, MT=010), P5 16-18 (S=001, rest 100), P6 19-20 (S=010); cycle 21 back to P1.
- Wrap/long run: 30+ cycles (≥300 ns at 10 ns clock) -> second pass repeats identical timing; one-hot and safety invariants checked every cycle.
- Mid-operation reset: assert rst during P3 (cycle 11) -> next edge lamps return to P1 values; sequence restarts with full 7-cycle P1.
- Parameter override: T_MG=3, T_Y=1, T_TG=2, T_SG=2 -> phase lengths 3,1,2,1,2,1; period 10 cycles.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Fixed-time Moore controller for a four-approach junction (M1, M2, MT, S).
// Six-phase cycle with per-phase durations in clock cycles; lamps are one-hot {red, yellow, green}.
module traffic_light_controller #(
  parameter int unsigned T_MG = 7,
  parameter int unsigned T_Y  = 2,
  parameter int unsigned T_TG = 5,
  parameter int unsigned T_SG = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  localparam int unsigned MaxA   = (T_MG > T_Y) ? T_MG : T_Y;
  localparam int unsigned MaxB   = (T_TG > T_SG) ? T_TG : T_SG;
  localparam int unsigned MaxDur = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = ($clog2(MaxDur) > 5) ? $clog2(MaxDur) : 5;

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  typedef enum logic [2:0] {
    StP1 = 3'd0,
    StP2 = 3'd1,
    StP3 = 3'd2,
    StP4 = 3'd3,
    StP5 = 3'd4,
    StP6 = 3'd5
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_last;
  logic              phase_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= StP1;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Terminal count of the current phase and legality of the phase encoding.
  always_comb begin
    cnt_last    = '0;
    phase_legal = 1'b1;
    case (phase_q)
      StP1:    cnt_last = CntW'(T_MG - 1);
      StP2:    cnt_last = CntW'(T_Y - 1);
      StP3:    cnt_last = CntW'(T_TG - 1);
      StP4:    cnt_last = CntW'(T_Y - 1);
      StP5:    cnt_last = CntW'(T_SG - 1);
      StP6:    cnt_last = CntW'(T_Y - 1);
      default: phase_legal = 1'b0;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    if (!phase_legal) begin
      phase_d = StP1;
      cnt_d   = '0;
    end else if (cnt_q == cnt_last) begin
      cnt_d = '0;
      case (phase_q)
        StP1:    phase_d = StP2;
        StP2:    phase_d = StP3;
        StP3:    phase_d = StP4;
        StP4:    phase_d = StP5;
        StP5:    phase_d = StP6;
        default: phase_d = StP1;
      endcase
    end
  end

  // Illegal encodings leave every approach on red.
  always_comb begin
    light_M1 = LampRed;
    light_M2 = LampRed;
    light_MT = LampRed;
    light_S  = LampRed;
    case (phase_q)
      StP1: begin
        light_M1 = LampGreen;
        light_M2 = LampGreen;
      end
      StP2: begin
        light_M1 = LampGreen;
        light_M2 = LampYellow;
      end
      StP3: begin
        light_M1 = LampGreen;
        light_MT = LampGreen;
      end
      StP4: begin
        light_M1 = LampYellow;
        light_MT = LampYellow;
      end
      StP5:    light_S = LampGreen;
      StP6:    light_S = LampYellow;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench: default-timing instance and a shortened-timing instance share clock and reset.
module tb_traffic_light_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam int NVec = 42;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] a_m1, a_s, a_mt, a_m2;
  logic [2:0] b_m1, b_s, b_mt, b_m2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut_a (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (a_m1),
    .light_S  (a_s),
    .light_MT (a_mt),
    .light_M2 (a_m2)
  );

  traffic_light_controller #(
    .T_MG (3),
    .T_Y  (1),
    .T_TG (2),
    .T_SG (2)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (b_m1),
    .light_S  (b_s),
    .light_MT (b_mt),
    .light_M2 (b_m2)
  );

  typedef struct {
    logic [11:0] exp_a;  // {M1, M2, MT, S}
    logic [11:0] exp_b;
  } vec_t;

  vec_t vecs[NVec];

  function automatic logic [11:0] lamps_of(input int p);
    case (p)
      0:       return {G, G, R, R};
      1:       return {G, Y, R, R};
      2:       return {G, R, G, R};
      3:       return {Y, R, Y, R};
      4:       return {R, R, R, G};
      default: return {R, R, R, Y};
    endcase
  endfunction

  function automatic int phase_at(input int k, input int d0, input int d1, input int d2,
                                  input int d3, input int d4, input int d5);
    int d[6];
    int r;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4; d[5] = d5;
    r = k % (d0 + d1 + d2 + d3 + d4 + d5);
    for (int p = 0; p < 6; p++) begin
      if (r < d[p]) return p;
      r -= d[p];
    end
    return 0;
  endfunction

  task automatic check_lamps(input string name, input int cyc, input logic [11:0] act,
                             input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_inv(input string name, input int cyc, input logic [11:0] act);
    logic [2:0] m1, m2, mt, s;
    logic ok;
    {m1, m2, mt, s} = act;
    ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s);
    if (s != R && (m1 != R || m2 != R || mt != R)) ok = 1'b0;
    if (mt != R && m2 != R) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s invariant cycle %0d: got %b expected one-hot and safe", name, cyc, act);
    end
  endtask

  task automatic check_both(input int cyc, input int vi);
    check_lamps("dflt", cyc, {a_m1, a_m2, a_mt, a_s}, vecs[vi].exp_a);
    check_lamps("short", cyc, {b_m1, b_m2, b_mt, b_s}, vecs[vi].exp_b);
    check_inv("dflt", cyc, {a_m1, a_m2, a_mt, a_s});
    check_inv("short", cyc, {b_m1, b_m2, b_mt, b_s});
  endtask

  initial begin
    for (int k = 0; k < NVec; k++) begin
      vecs[k].exp_a = lamps_of(phase_at(k, 7, 2, 5, 2, 3, 2));
      vecs[k].exp_b = lamps_of(phase_at(k, 3, 1, 2, 1, 2, 1));
    end

    // Reset held for several edges must keep P1 with no progress.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_lamps("rst_hold_a", i, {a_m1, a_m2, a_mt, a_s}, {G, G, R, R});
      check_lamps("rst_hold_b", i, {b_m1, b_m2, b_mt, b_s}, {G, G, R, R});
    end
    rst = 1'b0;

    // Two full default periods plus the short instance's four periods.
    for (int k = 0; k < NVec; k++) begin
      if (k > 0) @(negedge clk);
      check_both(k, k);
    end

    // Fresh reset, then a mid-P3 reset at cycle 11.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge clk);
      check_both(k, k);
    end
    check_lamps("mid_p3_a", 11, {a_m1, a_m2, a_mt, a_s}, {G, R, G, R});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_lamps("mid_rst_a", 0, {a_m1, a_m2, a_mt, a_s}, {G, G, R, R});
    for (int k = 1; k < 22; k++) begin
      @(negedge clk);
      check_both(k, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
